// File: rtl/nx1_wb_pkg.sv
// Shared definitions for the nx1 Wishbone initiator: FSM state encoding
// and the width of the optional bus timeout counter.
package nx1_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int TMO_W = 16;

endpackage

// File: rtl/nx1_wb_timeout.sv
// Bus timeout counter. Counts the cycles that enable is high and raises
// expired during the LIMIT-th such cycle, so the owner can abort on the
// same edge. clear returns the count to zero and wins over enable.
module nx1_wb_timeout
  import nx1_wb_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

  logic [TMO_W-1:0] count;

  // Count enabled cycles; clear whenever the owner is outside the wait window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TMO_W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/nx1_wb_initiator.sv
// Single-transfer Wishbone classic initiator: command in, one bus cycle,
// response out. IDLE -> BUS -> RESP, one transaction per 3 cycles at best.
// Optional feature: define NX1_WBI_TIMEOUT_EN to abort a bus cycle that
// sees no ack within TIMEOUT_CYCLES cycles (response flagged rsp_err_o).
//
// Handshakes: cmd and rsp are valid/ready. A command transfers on an edge
// where cmd_valid_i and cmd_ready_o are both high; a response transfers on
// an edge where rsp_valid_o and rsp_ready_i are both high. The initiator
// holds rsp_valid_o/rsp_dat_o/rsp_err_o stable until that edge and never
// queues a command while busy.
module nx1_wb_initiator
  import nx1_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy_o,
  output state_t      state_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("nx1_wb_initiator: TIMEOUT_CYCLES must be 1..65535");
  end

  state_t state_q, state_d;
  logic   accept, bus_done, timeout;
  logic   cyc_q;

`ifdef NX1_WBI_TIMEOUT_EN
  logic err_q;

  nx1_wb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clear   (state_q != BUS),
    .enable  (state_q == BUS),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state decode; ack wins over a coincident timeout.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    bus_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          accept  = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i || timeout) begin
          bus_done = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Bus-side registers: latch the command on accept, drop cyc on completion.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cyc_q     <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else if (accept) begin
      cyc_q     <= 1'b1;
      wbm_we_o  <= cmd_we_i;
      wbm_adr_o <= cmd_adr_i;
      wbm_dat_o <= cmd_dat_i;
      wbm_sel_o <= cmd_sel_i;
    end else if (bus_done) begin
      cyc_q     <= 1'b0;
    end
  end

  // Response registers: capture read data on ack, hold until consumed.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
    end else if (bus_done) begin
      rsp_valid_o <= 1'b1;
      rsp_dat_o   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : 32'd0;
    end else if (state_q == RESP && rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

`ifdef NX1_WBI_TIMEOUT_EN
  // Error flag: set only when the bus cycle ended without an ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)    err_q <= 1'b0;
    else if (bus_done) err_q <= !wbm_ack_i;
  end
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_nx1_wb_initiator.sv
// Self-checking bench for nx1_wb_initiator. A transaction-level model
// predicts every output each cycle; directed sequences pin the model with
// literal values. Timeout sequences run only with NX1_WBI_TIMEOUT_EN.
module tb_nx1_wb_initiator;
  import nx1_wb_pkg::*;

  localparam int T = 8;
`ifdef NX1_WBI_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] cmd_adr, cmd_dat, rsp_dat, wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  cmd_sel, wb_sel;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, busy;
  state_t      dut_state;

  nx1_wb_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (wb_cyc),
    .wbm_stb_o   (wb_stb),
    .wbm_we_o    (wb_we),
    .wbm_adr_o   (wb_adr),
    .wbm_dat_o   (wb_dat_o),
    .wbm_sel_o   (wb_sel),
    .wbm_ack_i   (wb_ack),
    .wbm_dat_i   (wb_dat_i),
    .busy_o      (busy),
    .state_o     (dut_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];   // read data of accepted transactions, in order

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // A transaction occupies the bus for a length fixed at accept time:
  // wait+1 cycles when the slave acks, TIMEOUT cycles when it never does.
  int          m_bus_left;   // bus cycles still to run (0 = not on the bus)
  int          m_elapsed;    // bus cycles already run for this transaction
  int          m_wait;       // slave wait states chosen for this transaction
  bit          m_ok;
  bit          m_rsp;
  logic        m_we;
  logic [31:0] m_adr, m_dat, m_rdval, m_rdat;
  logic [3:0]  m_sel;
  bit          m_err;
  int          next_wait;
  logic [31:0] next_rdata;
  bit          spur_en = 1'b1;

  task automatic model_reset();
    m_bus_left = 0; m_elapsed = 0; m_wait = 0; m_ok = 1'b1; m_rsp = 1'b0;
    m_we = 1'b0; m_adr = '0; m_dat = '0; m_sel = '0; m_rdval = '0;
    m_rdat = '0; m_err = 1'b0;
  endtask

  function automatic bit m_idle();
    return (m_bus_left == 0) && !m_rsp;
  endfunction

  // Slave: acks after exactly m_wait wait states; random ack noise elsewhere.
  task automatic drive_slave();
    if (m_bus_left > 0 && m_elapsed == m_wait) begin
      wb_ack   = 1'b1;
      wb_dat_i = m_rdval;
    end else begin
      wb_ack   = (m_bus_left == 0 && spur_en) ? 1'($urandom_range(0, 1)) : 1'b0;
      wb_dat_i = $urandom;
    end
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_advance();
    if (m_bus_left > 0) begin
      m_bus_left--;
      m_elapsed++;
      if (m_bus_left == 0) begin
        m_rsp  = 1'b1;
        m_err  = !m_ok;
        m_rdat = (m_ok && !m_we) ? m_rdval : 32'd0;
        void'(exp_q.pop_front());
      end
    end else if (m_rsp) begin
      if (rsp_ready) m_rsp = 1'b0;
    end else if (cmd_valid) begin
      m_we = cmd_we; m_adr = cmd_adr; m_dat = cmd_dat; m_sel = cmd_sel;
      m_wait = next_wait; m_rdval = next_rdata; m_elapsed = 0;
      m_ok = !(TMO_EN && next_wait >= T);
      m_bus_left = m_ok ? next_wait + 1 : T;
      exp_q.push_back(next_rdata);
    end
  endtask

  task automatic compare_all();
    state_t es;
    es = (m_bus_left > 0) ? BUS : (m_rsp ? RESP : IDLE);
    check("cyc", wb_cyc, m_bus_left > 0);
    check("stb", wb_stb, m_bus_left > 0);
    check("cmd_ready", cmd_ready, m_idle());
    check("busy", busy, !m_idle());
    check("state", 32'(dut_state), 32'(es));
    check("rsp_valid", rsp_valid, m_rsp);
    if (m_bus_left > 0) begin
      check("wb_we", wb_we, m_we);
      check("wb_adr", wb_adr, m_adr);
      check("wb_dat", wb_dat_o, m_dat);
      check("wb_sel", wb_sel, m_sel);
    end
    if (m_rsp) begin
      check("rsp_dat", rsp_dat, m_rdat);
      check("rsp_err", rsp_err, m_err);
    end
  endtask

  // One clock: slave reacts, model steps, edge, then compare on the falling edge.
  task automatic cycle();
    drive_slave();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int w, input logic [31:0] rd);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    next_wait = w; next_rdata = rd;
  endtask

  task automatic drain();
    int n;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (!m_idle() && n < 40) begin
      cycle();
      n++;
    end
    check("drain_bound", m_idle(), 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0; wb_ack = 1'b0; wb_dat_i = '0; next_wait = 0; next_rdata = '0;
    model_reset();

    // Reset state, with ack noise present.
    repeat (3) @(negedge clk);
    wb_ack = 1'b1;
    #1;
    compare_all();
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_wb_adr", wb_adr, 32'd0);
    check("rst_wb_we", wb_we, 1'b0);
    wb_ack = 1'b0;
    rst_n = 1'b1;
    cycle();

    // Zero-wait write: one stb cycle, response two cycles after accept.
    set_cmd(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 0, 32'hDEAD_BEEF);
    rsp_ready = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    check("d1_cyc", wb_cyc, 1'b1);
    check("d1_we", wb_we, 1'b1);
    check("d1_adr", wb_adr, 32'h3000_0004);
    check("d1_dat", wb_dat_o, 32'hA5A5_0001);
    check("d1_sel", wb_sel, 4'hF);
    cycle();
    check("d1_cyc_off", wb_cyc, 1'b0);
    check("d1_rsp_valid", rsp_valid, 1'b1);
    check("d1_rsp_dat", rsp_dat, 32'd0);
    check("d1_rsp_err", rsp_err, 1'b0);
    cycle();
    check("d1_rsp_gone", rsp_valid, 1'b0);
    check("d1_ready", cmd_ready, 1'b1);

    // Read with three wait states, then a stalled consumer.
    set_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, 3, 32'h1234_5678);
    cycle();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("d2_stb", wb_stb, 1'b1);
      cycle();
    end
    check("d2_stb_off", wb_stb, 1'b0);
    check("d2_rsp_dat", rsp_dat, 32'h1234_5678);
    rsp_ready = 1'b0;
    set_cmd(1'b1, 32'h3000_0010, 32'h0000_00AA, 4'h1, 0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("d3_ready_low", cmd_ready, 1'b0);
      check("d3_rsp_hold", rsp_dat, 32'h1234_5678);
    end
    rsp_ready = 1'b1;
    cycle();
    check("d3_ready_back", cmd_ready, 1'b1);
    check("d3_rsp_gone", rsp_valid, 1'b0);
    cycle();
    check("d3_second_accept", wb_cyc, 1'b1);
    check("d3_second_adr", wb_adr, 32'h3000_0010);
    drain();

    if (TMO_EN) begin
      // Slave never acks: abort after T bus cycles with an error response.
      set_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, 1000, 32'h5555_AAAA);
      rsp_ready = 1'b0;
      cycle();
      cmd_valid = 1'b0;
      for (int i = 0; i < T; i++) begin
        check("t1_cyc", wb_cyc, 1'b1);
        cycle();
      end
      check("t1_cyc_off", wb_cyc, 1'b0);
      check("t1_err", rsp_err, 1'b1);
      check("t1_dat", rsp_dat, 32'd0);
      drain();
      // Ack on the final allowed cycle wins.
      set_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF, T - 1, 32'hCAFE_F00D);
      rsp_ready = 1'b0;
      cycle();
      cmd_valid = 1'b0;
      repeat (T) cycle();
      check("t2_err", rsp_err, 1'b0);
      check("t2_dat", rsp_dat, 32'hCAFE_F00D);
      drain();
    end

    // Reset pulsed mid-transfer: bus drops at once, no response appears.
    set_cmd(1'b0, 32'h3000_0030, 32'h0, 4'hF, 5, 32'h0BAD_0BAD);
    cycle();
    cmd_valid = 1'b0;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("r_cyc", wb_cyc, 1'b0);
    check("r_stb", wb_stb, 1'b0);
    check("r_busy", busy, 1'b0);
    check("r_rsp_valid", rsp_valid, 1'b0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    set_cmd(1'b1, 32'h3000_0040, 32'h1111_2222, 4'h3, 0, 32'h0);
    cycle();
    check("r_first_accept", wb_cyc, 1'b1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cmd_valid  = ($urandom_range(0, 3) != 0);
      cmd_we     = 1'($urandom_range(0, 1));
      cmd_adr    = $urandom;
      cmd_dat    = $urandom;
      cmd_sel    = 4'($urandom_range(0, 15));
      rsp_ready  = ($urandom_range(0, 2) != 0);
      next_wait  = TMO_EN ? $urandom_range(0, T + 2) : $urandom_range(0, 6);
      next_rdata = $urandom;
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nx1_wb_initiator.md
NX1_WB_INITIATOR -- requirements
Module: nx1_wb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: the number of BUS-state cycles without an ack before the transfer is aborted (range 1..65535).
REQ-002 SHALL have port wb_clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port wb_rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid_i, input, 1 bit: a command is offered.
REQ-005 SHALL have port cmd_ready_o, output, 1 bit: the initiator can accept a command.
REQ-006 SHALL have port cmd_we_i, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_adr_i, input, 32 bits: byte address.
REQ-008 SHALL have port cmd_dat_i, input, 32 bits: write data.
REQ-009 SHALL have port cmd_sel_i, input, 4 bits: byte lanes.
REQ-010 SHALL have port rsp_valid_o, output, 1 bit: a response is available.
REQ-011 SHALL have port rsp_ready_i, input, 1 bit: the consumer accepts the response.
REQ-012 SHALL have port rsp_dat_o, output, 32 bits: read data; 0 for writes and timeouts.
REQ-013 SHALL have port rsp_err_o, output, 1 bit: the transfer timed out.
REQ-014 SHALL have ports wbm_cyc_o, wbm_stb_o and wbm_we_o, outputs, 1 bit each: Wishbone classic master controls.
REQ-015 SHALL have ports wbm_adr_o (32 bits), wbm_dat_o (32 bits) and wbm_sel_o (4 bits), outputs: Wishbone master address, data and byte lanes.
REQ-016 SHALL have ports wbm_ack_i (input, 1 bit) and wbm_dat_i (input, 32 bits): slave acknowledge and read data.
REQ-017 SHALL have port busy_o, output, 1 bit: the FSM is not in IDLE.

Function
REQ-018 SHALL implement an FSM with states IDLE, BUS and RESP; all outputs are registered except cmd_ready_o = (state==IDLE).
REQ-019 In IDLE, SHALL latch we/adr/dat/sel on the cmd_valid_i & cmd_ready_o edge, enter BUS, and drive wbm_cyc_o = wbm_stb_o = 1 from the next cycle.
REQ-020 In BUS, SHALL hold cyc, stb, we, adr, dat and sel stable until wbm_ack_i is sampled high.
REQ-021 On an ack edge, SHALL capture wbm_dat_i (reads only; writes capture 0), set rsp_err_o = 0, drop cyc/stb in the following cycle, and enter RESP with rsp_valid_o = 1.
REQ-022 With a zero-wait slave (ack in the first stb cycle), SHALL give command accept to rsp_valid_o latency of exactly 2 cycles.
REQ-023 In RESP, SHALL hold rsp_valid_o, rsp_dat_o and rsp_err_o stable until rsp_ready_i is sampled high, then return to IDLE with rsp_valid_o = 0 in the next cycle.
REQ-024 SHALL give a peak throughput of one transaction per 3 cycles.
REQ-025 SHALL ignore wbm_ack_i outside BUS.
REQ-026 SHALL keep cmd_valid_i with no effect while busy (ready low); no command is queued.
REQ-027 SHALL keep wbm_stb_o == wbm_cyc_o at all times; a single transfer per cycle, no bursts.

Reset
REQ-028 While wb_rst_ni = 0, SHALL immediately force state = IDLE, wbm_cyc_o/stb_o/we_o = 0, wbm_adr_o/dat_o/sel_o = 0, rsp_valid_o = 0, rsp_dat_o = 0, rsp_err_o = 0, busy_o = 0 and the timeout counter = 0.
REQ-029 A reset asserted mid-transfer SHALL abort the transfer with no response produced; the first command after release is accepted in the cycle following the release edge.

Configuration
REQ-030 With NX1_WBI_TIMEOUT_EN defined, SHALL count BUS cycles; when the count reaches TIMEOUT_CYCLES with no ack, SHALL drop cyc/stb next cycle and enter RESP with rsp_err_o = 1 and rsp_dat_o = 0.
REQ-031 With NX1_WBI_TIMEOUT_EN defined, an ack arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL take priority (success).
REQ-032 Without NX1_WBI_TIMEOUT_EN, SHALL wait indefinitely in BUS, tie rsp_err_o to 0, and contain no counter logic.

Structure
REQ-033 SHALL place the FSM state encoding (IDLE=2'd0, BUS=2'd1, RESP=2'd2) and the timeout counter width (16) in shared package nx1_wb_pkg.
REQ-034 SHALL implement the timeout as sub-module nx1_wb_timeout (inputs clear/enable; output expired), instantiated only under NX1_WBI_TIMEOUT_EN.

Verification
REQ-035 SHALL cover: write adr 0x3000_0004, dat 0xA5A5_0001, sel 0xF, zero-wait slave -> cyc/stb high exactly 1 cycle, we=1, rsp_valid 2 cycles after accept, rsp_dat=0, err=0.
REQ-036 SHALL cover: read adr 0x3000_0008, slave acks after 3 wait cycles with 0x1234_5678 -> stb high 4 cycles, rsp_dat=0x1234_5678.
REQ-037 SHALL cover: rsp_ready_i low for 5 cycles, cmd_valid_i held high -> cmd_ready_o stays 0 and rsp_dat_o is stable; second command accepted the cycle after the handshake.
REQ-038 SHALL cover: NX1_WBI_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave never acks -> cyc drops after 8 BUS cycles, rsp_err=1, rsp_dat=0.
REQ-039 SHALL cover: ack coincident with the 8th cycle -> err=0 and data captured.
REQ-040 SHALL cover: wb_rst_ni pulsed low during BUS -> cyc/stb low asynchronously, no rsp_valid, busy_o=0.
